// File: rtl/axis_packet_distributor.sv
// axis_packet_distributor
// Counts beats from one AXI-Stream source into fixed-size packets, marks
// TLAST on the final beat, and deals packets in groups of PP_GROUP to NCH
// output channels in round-robin order, skipping masked-off channels.
// Each output channel has a single register slot that drains independently.
// Optional feature macro: PPD_PKT_COUNT_EN adds per-channel completed-packet
// counters on PKT_COUNT.
module axis_packet_distributor #(
    parameter int DW  = 512,
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           PACKET_SIZE,
    input  logic [31:0]           PP_GROUP,
    input  logic [NCH-1:0]        CH_ENABLE,
    input  logic [DW-1:0]         AXIS_IN_TDATA,
    input  logic                  AXIS_IN_TVALID,
    output logic                  AXIS_IN_TREADY,
    output logic [NCH*DW-1:0]     AXIS_OUT_TDATA,
    output logic [NCH-1:0]        AXIS_OUT_TVALID,
    input  logic [NCH-1:0]        AXIS_OUT_TREADY,
    output logic [NCH*DW/8-1:0]   AXIS_OUT_TKEEP,
    output logic [NCH-1:0]        AXIS_OUT_TLAST,
    output logic [CW-1:0]         CUR_CH
`ifdef PPD_PKT_COUNT_EN
    ,
    output logic [NCH*32-1:0]     PKT_COUNT
`endif
);

    typedef enum logic {SELECT, STREAM} state_t;

    localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

    state_t              state;
    logic [31:0]         beat_cnt;
    logic [31:0]         pkt_cnt;
    logic [31:0]         pkt_size_q;
    logic [31:0]         grp_q;
    logic [31:0]         size_now;
    logic [31:0]         grp_now;
    logic                accept;
    logic                last_beat;
    logic                grp_done;
    logic                next_found;
    logic [CW-1:0]       next_ch;
    logic [CW:0]         cand;

    logic [NCH*DW-1:0]   data_p0;
    logic [NCH*DW/8-1:0] keep_p0;
    logic [NCH-1:0]      last_p0;
    logic [NCH-1:0]      vld_p0;

    // Zero sizes are treated as one so a packet or group is never empty.
    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // The first beat of a packet uses the freshly sampled sizes, later beats the held copies.
    assign size_now  = (beat_cnt == 32'd0) ? at_least_one(PACKET_SIZE) : pkt_size_q;
    assign grp_now   = (beat_cnt == 32'd0) ? at_least_one(PP_GROUP)    : grp_q;
    assign last_beat = (beat_cnt == size_now - 32'd1);
    assign grp_done  = (pkt_cnt == grp_now - 32'd1);

    assign AXIS_IN_TREADY = (state == STREAM) &&
                            (!vld_p0[CUR_CH] || AXIS_OUT_TREADY[CUR_CH]);
    assign accept = AXIS_IN_TVALID && AXIS_IN_TREADY;

    assign AXIS_OUT_TDATA  = data_p0;
    assign AXIS_OUT_TKEEP  = keep_p0;
    assign AXIS_OUT_TLAST  = last_p0;
    assign AXIS_OUT_TVALID = vld_p0;

    // Find the first enabled channel after CUR_CH, wrapping; the lowest offset wins.
    always_comb begin
        next_found = 1'b0;
        next_ch    = CUR_CH;
        cand       = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = {1'b0, CUR_CH} + (CW+1)'(i);
            if (cand >= NCH_W) cand = cand - NCH_W;
            if (CH_ENABLE[cand[CW-1:0]]) begin
                next_found = 1'b1;
                next_ch    = cand[CW-1:0];
            end
        end
    end

    // Channel selection, beat/packet counting and group switching.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= SELECT;
            CUR_CH     <= CW'(NCH-1);
            beat_cnt   <= 32'd0;
            pkt_cnt    <= 32'd0;
            pkt_size_q <= 32'd1;
            grp_q      <= 32'd1;
        end else begin
            case (state)
                SELECT: begin
                    if (next_found) begin
                        CUR_CH <= next_ch;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (beat_cnt == 32'd0) begin
                            pkt_size_q <= size_now;
                            grp_q      <= grp_now;
                        end
                        if (last_beat) begin
                            beat_cnt <= 32'd0;
                            // A disabled channel finishes its packet, then gives up the group.
                            if (grp_done || !CH_ENABLE[CUR_CH]) begin
                                pkt_cnt <= 32'd0;
                                state   <= SELECT;
                            end else begin
                                pkt_cnt <= pkt_cnt + 32'd1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 32'd1;
                        end
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end

    // Output stage: one slot per channel, loaded from the input, drained by its own ready.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!resetn) begin
                data_p0[k*DW +: DW]     <= '0;
                keep_p0[k*DW/8 +: DW/8] <= '0;
                last_p0[k]              <= 1'b0;
                vld_p0[k]               <= 1'b0;
            end else if (accept && (CUR_CH == CW'(k))) begin
                data_p0[k*DW +: DW]     <= AXIS_IN_TDATA;
                keep_p0[k*DW/8 +: DW/8] <= '1;
                last_p0[k]              <= last_beat;
                vld_p0[k]               <= 1'b1;
            end else if (AXIS_OUT_TREADY[k]) begin
                vld_p0[k]               <= 1'b0;
            end
        end
    end

`ifdef PPD_PKT_COUNT_EN
    // Count packets whose final beat left each channel.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!resetn) begin
                PKT_COUNT[k*32 +: 32] <= 32'd0;
            end else if (vld_p0[k] && AXIS_OUT_TREADY[k] && last_p0[k]) begin
                PKT_COUNT[k*32 +: 32] <= PKT_COUNT[k*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_packet_distributor.sv
// Testbench for axis_packet_distributor: table-driven beat vectors feed a
// per-channel scoreboard; hand-written sequences cover backpressure, an
// all-masked enable, a mid-packet size change and a mid-packet reset.
// Build with PPD_PKT_COUNT_EN defined to also check PKT_COUNT.
module tb_axis_packet_distributor;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CW  = $clog2(NCH);
    localparam int KW  = NCH*DW/8;

    logic              clk;
    logic              resetn;
    logic [31:0]       PACKET_SIZE;
    logic [31:0]       PP_GROUP;
    logic [NCH-1:0]    CH_ENABLE;
    logic [DW-1:0]     AXIS_IN_TDATA;
    logic              AXIS_IN_TVALID;
    logic              AXIS_IN_TREADY;
    logic [NCH*DW-1:0] AXIS_OUT_TDATA;
    logic [NCH-1:0]    AXIS_OUT_TVALID;
    logic [NCH-1:0]    AXIS_OUT_TREADY;
    logic [KW-1:0]     AXIS_OUT_TKEEP;
    logic [NCH-1:0]    AXIS_OUT_TLAST;
    logic [CW-1:0]     CUR_CH;
`ifdef PPD_PKT_COUNT_EN
    logic [NCH*32-1:0] PKT_COUNT;
`endif

    axis_packet_distributor #(.DW(DW), .NCH(NCH)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .PACKET_SIZE     (PACKET_SIZE),
        .PP_GROUP        (PP_GROUP),
        .CH_ENABLE       (CH_ENABLE),
        .AXIS_IN_TDATA   (AXIS_IN_TDATA),
        .AXIS_IN_TVALID  (AXIS_IN_TVALID),
        .AXIS_IN_TREADY  (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .AXIS_OUT_TKEEP  (AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
        .CUR_CH          (CUR_CH)
`ifdef PPD_PKT_COUNT_EN
        ,
        .PKT_COUNT       (PKT_COUNT)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [31:0]    psize;
        logic [31:0]    grp;
        logic [NCH-1:0] en;
        logic [DW-1:0]  data;
        int             ch;
        logic           last;
        int             wait_cyc;
        logic           reset_first;
    } vec_t;

    exp_t           sb[NCH][$];
    vec_t           vecs[$];
    int             n_chk;
    int             n_pass;
    int             stall_cnt;
    logic [NCH-1:0] rdy_mask;

    logic [NCH-1:0] pv;
    logic [NCH-1:0] pr;
    logic [NCH-1:0] pl;
    logic [DW-1:0]  pd[NCH];
    logic           prst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Output ready driver: channel 0 can be held low for stall_cnt cycles.
    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            AXIS_OUT_TREADY = rdy_mask & {{(NCH-1){1'b1}}, 1'b0};
            stall_cnt = stall_cnt - 1;
        end else begin
            AXIS_OUT_TREADY = rdy_mask;
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks holding.
    initial begin
        prst = 1'b0;
        pv = '0;
        pr = '0;
        pl = '0;
        for (int k = 0; k < NCH; k++) pd[k] = '0;
    end

    always @(negedge clk) begin
        #2;
        for (int k = 0; k < NCH; k++) begin
            if (prst && resetn && pv[k] && !pr[k]) begin
                chk($sformatf("ch%0d hold valid", k), AXIS_OUT_TVALID[k], 1'b1);
                chk($sformatf("ch%0d hold data", k), AXIS_OUT_TDATA[k*DW +: DW], pd[k]);
                chk($sformatf("ch%0d hold last", k), AXIS_OUT_TLAST[k], pl[k]);
            end
            if (resetn && AXIS_OUT_TVALID[k] && AXIS_OUT_TREADY[k]) begin
                chk($sformatf("ch%0d beat expected", k), sb[k].size() != 0, 1'b1);
                if (sb[k].size() != 0) begin
                    exp_t e;
                    e = sb[k].pop_front();
                    chk($sformatf("ch%0d data", k), AXIS_OUT_TDATA[k*DW +: DW], e.data);
                    chk($sformatf("ch%0d last", k), AXIS_OUT_TLAST[k], e.last);
                    chk($sformatf("ch%0d keep", k), AXIS_OUT_TKEEP[k*DW/8 +: DW/8], {(DW/8){1'b1}});
                end
            end
            pv[k] = AXIS_OUT_TVALID[k];
            pr[k] = AXIS_OUT_TREADY[k];
            pl[k] = AXIS_OUT_TLAST[k];
            pd[k] = AXIS_OUT_TDATA[k*DW +: DW];
        end
        prst = resetn;
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset out tvalid", AXIS_OUT_TVALID, '0);
        chk("reset out tlast", AXIS_OUT_TLAST, '0);
        chk("reset out tdata zero", AXIS_OUT_TDATA == '0, 1'b1);
        chk("reset out tkeep", AXIS_OUT_TKEEP, '0);
        chk("reset in tready", AXIS_IN_TREADY, 1'b0);
        chk("reset cur_ch", CUR_CH, NCH-1);
`ifdef PPD_PKT_COUNT_EN
        chk("reset pkt_count zero", PKT_COUNT == '0, 1'b1);
`endif
        for (int k = 0; k < NCH; k++) sb[k].delete();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_beat(input string name, input logic [DW-1:0] data, input int ch,
                             input logic last, input int wait_exp);
        int   waited;
        logic ok;
        exp_t e;
        waited = 0;
        ok = 1'b0;
        @(negedge clk);
        AXIS_IN_TDATA  = data;
        AXIS_IN_TVALID = 1'b1;
        #1;
        while (!ok && waited < 200) begin
            if (AXIS_IN_TREADY === 1'b1) begin
                ok = 1'b1;
                e.data = data;
                e.last = last;
                sb[ch].push_back(e);
            end else begin
                @(negedge clk);
                #1;
                waited++;
            end
        end
        chk({name, " handshake"}, ok, 1'b1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        AXIS_IN_TVALID = 1'b0;
        chk({name, " ready-low cycles"}, waited, wait_exp);
    endtask

    task automatic drain();
        rdy_mask = '1;
        repeat (4) @(negedge clk);
        #3;
        for (int k = 0; k < NCH; k++)
            chk($sformatf("ch%0d all beats delivered", k), sb[k].size(), 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        stall_cnt = 0;
        rdy_mask = '1;
        resetn = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        AXIS_IN_TDATA = '0;
        PACKET_SIZE = 32'd4;
        PP_GROUP = 32'd2;
        CH_ENABLE = '1;

        // Round robin: 4-beat packets, groups of 2, all channels.
        for (int v = 0; v < 32; v++)
            vecs.push_back('{32'd4, 32'd2, 4'b1111, DW'(v), v / 8, (v % 4) == 3,
                             (v != 0 && v % 8 == 0) ? 1 : 0, v == 0});
        // Masked: only channels 1 and 3, 2-beat packets, one packet per group.
        for (int v = 0; v < 8; v++)
            vecs.push_back('{32'd2, 32'd1, 4'b1010, DW'(100 + v), ((v / 2) % 2 == 1) ? 3 : 1,
                             (v % 2) == 1, (v != 0 && v % 2 == 0) ? 1 : 0, v == 0});
        // Degenerate: zero sizes act as one beat and one packet.
        for (int v = 0; v < 8; v++)
            vecs.push_back('{32'd0, 32'd0, 4'b1111, DW'(200 + v), v % 4, 1'b1,
                             (v != 0) ? 1 : 0, v == 0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].reset_first) begin
                if (i != 0) drain();
`ifdef PPD_PKT_COUNT_EN
                if (i == 32)
                    for (int k = 0; k < NCH; k++)
                        chk($sformatf("ch%0d pkt_count", k), PKT_COUNT[k*32 +: 32], 32'd2);
`endif
                PACKET_SIZE = vecs[i].psize;
                PP_GROUP    = vecs[i].grp;
                CH_ENABLE   = vecs[i].en;
                do_reset();
            end
            send_beat($sformatf("vec%0d", i), vecs[i].data, vecs[i].ch,
                      vecs[i].last, vecs[i].wait_cyc);
        end
        drain();

        // Backpressure: channel 0 ready low for 5 cycles after the first beat.
        PACKET_SIZE = 32'd4;
        PP_GROUP = 32'd2;
        CH_ENABLE = 4'b1111;
        do_reset();
        send_beat("bp0", 32'h300, 0, 1'b0, 0);
        stall_cnt = 5;
        send_beat("bp1", 32'h301, 0, 1'b0, 5);
        for (int v = 2; v < 8; v++)
            send_beat($sformatf("bp%0d", v), DW'(32'h300 + v), 0, (v % 4) == 3, 0);
        drain();

        // All channels masked: input never ready; then a single enabled channel re-selects itself.
        CH_ENABLE = 4'b0000;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("masked tready", AXIS_IN_TREADY, 1'b0);
            chk("masked cur_ch", CUR_CH, NCH-1);
        end
        CH_ENABLE = 4'b0100;
        for (int v = 0; v < 8; v++)
            send_beat($sformatf("single%0d", v), DW'(32'h400 + v), 2, (v % 4) == 3, 0);
        send_beat("single8", 32'h408, 2, 1'b0, 1);
        drain();

        // Packet size changed mid-packet applies from the next packet.
        PACKET_SIZE = 32'd4;
        PP_GROUP = 32'd1;
        CH_ENABLE = 4'b1111;
        do_reset();
        send_beat("sz0", 32'h500, 0, 1'b0, 0);
        PACKET_SIZE = 32'd2;
        send_beat("sz1", 32'h501, 0, 1'b0, 0);
        send_beat("sz2", 32'h502, 0, 1'b0, 0);
        send_beat("sz3", 32'h503, 0, 1'b1, 0);
        send_beat("sz4", 32'h504, 1, 1'b0, 1);
        send_beat("sz5", 32'h505, 1, 1'b1, 0);
        send_beat("sz6", 32'h506, 2, 1'b0, 1);
        drain();

        // Reset in the middle of a packet on channel 1.
        PACKET_SIZE = 32'd4;
        do_reset();
        for (int v = 0; v < 4; v++)
            send_beat($sformatf("rm%0d", v), DW'(32'h600 + v), 0, v == 3, 0);
        send_beat("rm4", 32'h604, 1, 1'b0, 1);
        send_beat("rm5", 32'h605, 1, 1'b0, 0);
        rdy_mask = '0;
        do_reset();
        rdy_mask = '1;
        for (int v = 0; v < 4; v++)
            send_beat($sformatf("rr%0d", v), DW'(32'h610 + v), 0, v == 3, 0);
        send_beat("rr4", 32'h614, 1, 1'b0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_packet_distributor.md
# axis_packet_distributor

N-way packet distributor for a single AXI-Stream source. It counts beats into fixed-size packets, appends TLAST, and deals packets in groups to NCH output channels in round-robin order, skipping any channel that is masked off. It is the multi-channel successor of the two-way ping-pong splitter and sits between the capture/DMA front end and parallel processing lanes.

## Interface
- DW, 512: data width in bits; multiple of 8.
- NCH, 4: number of output channels, 2..8.
- CW, $clog2(NCH): channel index width; derived, never overridden.
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- PACKET_SIZE  in  32  beats per packet; 0 is treated as 1.
- PP_GROUP  in  32  consecutive packets per channel before switching; 0 is treated as 1.
- CH_ENABLE  in  NCH  per-channel enable mask.
- AXIS_IN_TDATA  in  DW  input data.
- AXIS_IN_TVALID  in  1  input valid.
- AXIS_IN_TREADY  out  1  input ready.
- AXIS_OUT_TDATA  out  NCH*DW  channel k occupies bits [k*DW +: DW].
- AXIS_OUT_TVALID  out  NCH  per-channel valid.
- AXIS_OUT_TREADY  in  NCH  per-channel ready.
- AXIS_OUT_TKEEP  out  NCH*DW/8  channel k occupies bits [k*DW/8 +: DW/8].
- AXIS_OUT_TLAST  out  NCH  per-channel last.
- CUR_CH  out  CW  channel currently being filled.

## Operation
- FSM states:
  - SELECT: searches CH_ENABLE starting at CUR_CH+1 (mod NCH) and loads the first set bit into CUR_CH. It then goes to STREAM. If CH_ENABLE is 0, it stays in SELECT.
  - STREAM: passes beats to channel CUR_CH.
- Each channel has one output register slot: data, keep, last, valid.
- AXIS_IN_TREADY = (state==STREAM) && (!AXIS_OUT_TVALID[CUR_CH] || AXIS_OUT_TREADY[CUR_CH]).
- On an input handshake:
  - The slot at CUR_CH loads TDATA and TKEEP = all ones.
  - TLAST = (beat_cnt == pkt_size_q-1).
  - The slot's valid is set.
- A slot's valid clears when it is consumed and not reloaded in the same cycle.
- Counters:
  - beat_cnt counts 0..pkt_size_q-1 and wraps to 0 after the TLAST beat.
  - pkt_cnt increments on each TLAST beat.
  - When pkt_cnt reaches grp_q-1 on a TLAST beat, pkt_cnt resets to 0 and the FSM goes to SELECT.
- pkt_size_q and grp_q are sampled from the ports, with 0→1 substitution, on the first beat of every packet (beat_cnt==0). Changes made mid-packet take effect at the next packet. Changes made mid-group change the group length from the next packet onward.
- If CH_ENABLE[CUR_CH] drops mid-group, the current packet completes, then the FSM goes to SELECT. A packet is never split across channels.
- If only one channel is enabled, SELECT re-selects that same channel.
- Counter widths are 32 bits. Compare using equality only, so there is no overflow path.

## Timing
- Reset values:
  - All AXIS_OUT_TVALID/TLAST = 0; TDATA = 0; TKEEP = 0.
  - AXIS_IN_TREADY = 0.
  - State = SELECT; CUR_CH = NCH-1, so the first selection is channel 0 when it is enabled.
  - beat_cnt = 0, pkt_cnt = 0.
- Latency: an input handshake in cycle t gives output TVALID in cycle t+1.
- Throughput: 1 beat/cycle within a group. There is exactly one bubble cycle per group boundary (the SELECT cycle).
- Output slots of non-current channels keep draining independently while another channel is being filled.
- Holding rule: with TVALID high and TREADY low, the slot's TDATA, TKEEP and TLAST hold stable.
- Reset asserted mid-packet:
  - All slots are dropped and counters clear at the next edge.
  - The next accepted beat starts a new packet on channel 0, or on the first enabled channel.

## Configuration
- Macro PPD_PKT_COUNT_EN.
- Defined:
  - Adds output PKT_COUNT (NCH*32 bits).
  - Channel k's counter is the number of TLAST beats consumed on channel k (TVALID&TREADY&TLAST).
  - Each counter wraps at 2^32 and resets to 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Round-robin order:
  - Stimulus: NCH=4, PACKET_SIZE=4, PP_GROUP=2, CH_ENABLE=4'b1111, 32 continuous beats with values 0..31, all outputs ready.
  - Required: channel 0 gets 0–7, ch1 8–15, ch2 16–23, ch3 24–31. TLAST on values 3,7,11,…,31. One TREADY-low cycle after beats 7, 15, 23.
- Backpressure:
  - Stimulus: AXIS_OUT_TREADY[0] low for 5 cycles after the first beat.
  - Required: TREADY low after slot 0 fills. Slot data stable. No beat lost or duplicated. Resumes at 1 beat/cycle.
- Masking:
  - Stimulus: CH_ENABLE=4'b1010, PACKET_SIZE=2, PP_GROUP=1.
  - Required: packets alternate ch1, ch3, ch1. Channels 0 and 2 never assert TVALID.
  - Stimulus: CH_ENABLE=0. Required: TREADY stays low.
- Degenerate sizes:
  - Stimulus: PACKET_SIZE=0, PP_GROUP=0.
  - Required: every beat has TLAST and the channel advances after every beat. PACKET_SIZE changed from 4 to 2 mid-packet takes effect only at the next packet.
- Reset mid-packet:
  - Stimulus: resetn low for 1 cycle after beat 2 of a 4-beat packet on ch1.
  - Required: all TVALID = 0 next cycle. The next beat lands on ch0 with beat_cnt 0.
- PPD_PKT_COUNT_EN defined:
  - Stimulus: the round-robin scenario above.
  - Required: PKT_COUNT = 2 for each channel after drain, and 0 after reset.
